// File: rtl/simmem_linkedlist_bank.sv
// ---------------------------------------------------------------------------
// simmem_linkedlist_bank
//
// Shared-storage bank of NumIds independent FIFOs. All IDs draw entries from
// one pool of TotalCapacity slots. Each ID's queue is a singly linked list
// threaded through a next-element RAM. Payloads live in a parallel struct
// RAM. Free slots are tracked in a bit mask, and enqueue always takes the
// lowest-index free slot.
//
// Parameters
//   NumIds        number of per-ID queues (>= 2, power of two)
//   TotalCapacity shared entries across all IDs (>= 2, power of two)
//   DataWidth     payload width in bits
//
// Ports
//   clk_i        single clock; all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   enqueue request
//   in_ready_o   at least one slot is free (registered state only)
//   in_id_i      target queue of the enqueue
//   in_data_i    enqueue payload
//   out_id_i     queue selected for release
//   out_valid_o  selected queue is non-empty
//   out_ready_i  consumer takes the head of the selected queue
//   out_data_o   head payload of the selected queue
//   id_count_o   per-ID occupancy, ID 0 in the LSBs
//
// Build option
//   SIMMEM_BANK_OCCUPANCY_EN  when defined, id_count_o carries the live
//                             per-ID counts; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module simmem_linkedlist_bank #(
    parameter int NumIds        = 4,
    parameter int TotalCapacity = 16,
    parameter int DataWidth     = 32,
    localparam int IdWidth      = $clog2(NumIds),
    localparam int PtrWidth     = $clog2(TotalCapacity),
    localparam int CntWidth     = PtrWidth + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [IdWidth-1:0]           in_id_i,
    input  logic [DataWidth-1:0]         in_data_i,

    input  logic [IdWidth-1:0]           out_id_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DataWidth-1:0]         out_data_o,

    output logic [NumIds*CntWidth-1:0]   id_count_o
);

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DataWidth-1:0] data_ram [TotalCapacity];
    logic [PtrWidth-1:0]  next_ram [TotalCapacity];

    logic [TotalCapacity-1:0] free_mask;

    logic [PtrWidth-1:0] head  [NumIds];
    logic [PtrWidth-1:0] tail  [NumIds];
    logic [CntWidth-1:0] count [NumIds];

    logic [PtrWidth-1:0] head_next  [NumIds];
    logic [PtrWidth-1:0] tail_next  [NumIds];
    logic [CntWidth-1:0] count_next [NumIds];

    logic [PtrWidth-1:0] alloc_idx;
    logic [PtrWidth-1:0] rel_idx;
    logic                enq_fire;
    logic                rel_fire;
    logic                link_we;
    logic [PtrWidth-1:0] link_addr;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    // in_ready_o looks only at registered free bits. A slot released this
    // cycle is therefore not allocatable until the next cycle.
    assign in_ready_o  = |free_mask;
    assign enq_fire    = in_valid_i && in_ready_o;

    assign out_valid_o = (count[out_id_i] != '0);
    assign rel_idx     = head[out_id_i];
    assign out_data_o  = data_ram[rel_idx];
    assign rel_fire    = out_valid_o && out_ready_i;

    // -----------------------------------------------------------------------
    // Lowest-index free slot
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any conditional
    // assignment. That way no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
        alloc_idx = '0;
        // Scanning down lets the lowest set bit overwrite higher ones.
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_idx = PtrWidth'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-ID pointer and count update
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            head_next[i]  = head[i];
            tail_next[i]  = tail[i];
            count_next[i] = count[i];
        end
        link_we   = 1'b0;
        link_addr = tail[in_id_i];

        if (rel_fire) begin
            head_next[out_id_i]  = next_ram[rel_idx];
            count_next[out_id_i] = count[out_id_i] - CntWidth'(1);
        end

        if (enq_fire) begin
            // Build on count_next so that an enqueue and a release on the
            // same ID leave the count unchanged.
            count_next[in_id_i] = count_next[in_id_i] + CntWidth'(1);
            // The queue is empty, or its only entry leaves this cycle. In
            // both cases the new entry becomes both head and tail, and no
            // link needs writing.
            if ((count[in_id_i] == '0) ||
                (rel_fire && (out_id_i == in_id_i) &&
                 (count[in_id_i] == CntWidth'(1)))) begin
                head_next[in_id_i] = alloc_idx;
                tail_next[in_id_i] = alloc_idx;
            end else begin
                tail_next[in_id_i] = alloc_idx;
                link_we            = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers
    // therefore sample the pre-edge values and update together, which avoids
    // ordering races between always blocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_mask <= '1;
            for (int i = 0; i < NumIds; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            // The allocated slot was free and the released head was not, so
            // these two writes never target the same bit.
            if (enq_fire) begin
                free_mask[alloc_idx] <= 1'b0;
            end
            if (rel_fire) begin
                free_mask[rel_idx] <= 1'b1;
            end
            for (int i = 0; i < NumIds; i++) begin
                head[i]  <= head_next[i];
                tail[i]  <= tail_next[i];
                count[i] <= count_next[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Payload and link RAMs
    // -----------------------------------------------------------------------
    // NOTE: the RAMs are deliberately left without reset. A slot is only
    // read after an enqueue has written it, so clearing the arrays would add
    // reset fan-out and gain nothing.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            data_ram[alloc_idx] <= in_data_i;
        end
        if (link_we) begin
            next_ram[link_addr] <= alloc_idx;
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy output
    // -----------------------------------------------------------------------
`ifdef SIMMEM_BANK_OCCUPANCY_EN
    always_comb begin
        id_count_o = '0;
        for (int i = 0; i < NumIds; i++) begin
            id_count_o[i*CntWidth +: CntWidth] = count[i];
        end
    end
`else
    assign id_count_o = '0;
`endif

endmodule

// File: tb/tb_simmem_linkedlist_bank.sv
module tb_simmem_linkedlist_bank;

    localparam int NumIds        = 4;
    localparam int TotalCapacity = 16;
    localparam int DataWidth     = 32;
    localparam int CntWidth      = 5;

    logic                       clk_i;
    logic                       rst_i;
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [1:0]                 in_id_i;
    logic [DataWidth-1:0]       in_data_i;
    logic [1:0]                 out_id_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [DataWidth-1:0]       out_data_o;
    logic [NumIds*CntWidth-1:0] id_count_o;

    simmem_linkedlist_bank #(
        .NumIds        (NumIds),
        .TotalCapacity (TotalCapacity),
        .DataWidth     (DataWidth)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_id_i     (in_id_i),
        .in_data_i   (in_data_i),
        .out_id_i    (out_id_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .id_count_o  (id_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic step(input logic v, input logic [1:0] id, input logic [31:0] d,
                        input logic [1:0] oid, input logic ordy);
        @(negedge clk_i);
        in_valid_i  = v;
        in_id_i     = id;
        in_data_i   = d;
        out_id_i    = oid;
        out_ready_i = ordy;
        #1;
    endtask

    typedef struct {
        logic        in_valid;
        logic [1:0]  in_id;
        logic [31:0] in_data;
        logic [1:0]  out_id;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic v, input logic [1:0] id, input logic [31:0] d,
                                input logic [1:0] oid, input logic ordy,
                                input logic er, input logic ev, input logic [31:0] ed);
        vec_t r;
        r.in_valid  = v;
        r.in_id     = id;
        r.in_data   = d;
        r.out_id    = oid;
        r.out_ready = ordy;
        r.exp_ready = er;
        r.exp_valid = ev;
        r.exp_data  = ed;
        return r;
    endfunction

    logic [31:0] exp_cnt1;

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_id_i     = 2'd0;
        in_data_i   = '0;
        out_id_i    = 2'd0;
        out_ready_i = 1'b0;

        // Expected outputs are those visible before the edge that applies the row.
        // FIFO order on ID1 with head visibility one cycle after enqueue
        vecs[0]  = mk(1'b1, 2'd1, 32'hA,  2'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 2'd1, 32'hB,  2'd1, 1'b0, 1'b1, 1'b1, 32'hA);
        vecs[2]  = mk(1'b1, 2'd1, 32'hC,  2'd1, 1'b0, 1'b1, 1'b1, 32'hA);
        vecs[3]  = mk(1'b0, 2'd0, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'hA);
        vecs[4]  = mk(1'b0, 2'd0, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'hB);
        vecs[5]  = mk(1'b0, 2'd0, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'hC);
        vecs[6]  = mk(1'b0, 2'd0, 32'h0,  2'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        // Same-ID enqueue and release with count 1
        vecs[7]  = mk(1'b1, 2'd2, 32'h5,  2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 2'd2, 32'h6,  2'd2, 1'b1, 1'b1, 1'b1, 32'h5);
        vecs[9]  = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b0, 1'b1, 1'b1, 32'h6);
        vecs[10] = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b1, 1'b1, 1'b1, 32'h6);
        vecs[11] = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
        // Enqueue and release on different IDs in the same cycle
        vecs[12] = mk(1'b1, 2'd3, 32'h9,  2'd3, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[13] = mk(1'b1, 2'd0, 32'h1,  2'd3, 1'b1, 1'b1, 1'b1, 32'h9);
        vecs[14] = mk(1'b0, 2'd0, 32'h0,  2'd0, 1'b0, 1'b1, 1'b1, 32'h1);
        vecs[15] = mk(1'b0, 2'd0, 32'h0,  2'd3, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[16] = mk(1'b0, 2'd0, 32'h0,  2'd0, 1'b1, 1'b1, 1'b1, 32'h1);
        vecs[17] = mk(1'b0, 2'd0, 32'h0,  2'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        // Same-ID enqueue and release with count > 1
        vecs[18] = mk(1'b1, 2'd2, 32'h20, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
        vecs[19] = mk(1'b1, 2'd2, 32'h21, 2'd2, 1'b0, 1'b1, 1'b1, 32'h20);
        vecs[20] = mk(1'b1, 2'd2, 32'h22, 2'd2, 1'b1, 1'b1, 1'b1, 32'h20);
        vecs[21] = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b1, 1'b1, 1'b1, 32'h21);
        vecs[22] = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b1, 1'b1, 1'b1, 32'h22);
        vecs[23] = mk(1'b0, 2'd0, 32'h0,  2'd2, 1'b0, 1'b1, 1'b0, 32'h0);

        // ---- reset state ----
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
        check("rst_id_count", {12'b0, id_count_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready_o}, 32'h1);

        // ---- table-driven vectors ----
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].in_valid, vecs[i].in_id, vecs[i].in_data,
                 vecs[i].out_id, vecs[i].out_ready);
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready_o}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid_o}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_out_data", i), out_data_o, vecs[i].exp_data);
            end
        end

        // ---- fill all 16 entries alternating ID0/ID3 ----
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 2 == 1) ? 2'd3 : 2'd0, 32'h100 + 32'(i), 2'd0, 1'b0);
            check($sformatf("fill%0d_ready", i), {31'b0, in_ready_o}, 32'h1);
        end
        step(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
        check("full_in_ready", {31'b0, in_ready_o}, 32'h0);
        check("full_head0", out_data_o, 32'h100);
        // A release with a pending enqueue: the freed slot is not usable yet.
        step(1'b1, 2'd1, 32'h55, 2'd0, 1'b1);
        check("full_rel_no_accept", {31'b0, in_ready_o}, 32'h0);
        check("full_rel_data", out_data_o, 32'h100);
        step(1'b1, 2'd1, 32'h55, 2'd1, 1'b0);
        check("freed_accept_ready", {31'b0, in_ready_o}, 32'h1);
        check("freed_not_yet_visible", {31'b0, out_valid_o}, 32'h0);
        step(1'b0, 2'd0, 32'h0, 2'd1, 1'b0);
        check("refill_visible", {31'b0, out_valid_o}, 32'h1);
        check("refill_data", out_data_o, 32'h55);
        check("refull_in_ready", {31'b0, in_ready_o}, 32'h0);

        // ---- drain and confirm per-ID order ----
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 2'd0, 32'h0, 2'd3, 1'b1);
            check($sformatf("drain3_%0d", k), out_data_o, 32'h101 + 32'(2 * k));
        end
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 2'd0, 32'h0, 2'd0, 1'b1);
            check($sformatf("drain0_%0d", k), out_data_o, 32'h102 + 32'(2 * k));
        end
        step(1'b0, 2'd0, 32'h0, 2'd1, 1'b1);
        check("drain1_data", out_data_o, 32'h55);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd0, 32'h0, 2'(k), 1'b0);
            check($sformatf("empty_id%0d", k), {31'b0, out_valid_o}, 32'h0);
        end

        // ---- occupancy output ----
        step(1'b1, 2'd1, 32'h31, 2'd1, 1'b0);
        step(1'b1, 2'd1, 32'h32, 2'd1, 1'b0);
        step(1'b1, 2'd1, 32'h33, 2'd1, 1'b0);
        step(1'b1, 2'd0, 32'h41, 2'd1, 1'b0);
        step(1'b1, 2'd0, 32'h42, 2'd1, 1'b0);
        step(1'b0, 2'd0, 32'h0,  2'd1, 1'b0);
`ifdef SIMMEM_BANK_OCCUPANCY_EN
        exp_cnt1 = 32'd3;
`else
        exp_cnt1 = 32'd0;
`endif
        check("id_count_field1", {27'b0, id_count_o[CntWidth +: CntWidth]}, exp_cnt1);
        check("five_queued_head1", out_data_o, 32'h31);

        // ---- reset mid-cycle with 5 entries queued ----
        @(negedge clk_i);
        in_valid_i  = 1'b1;
        in_id_i     = 2'd2;
        in_data_i   = 32'hEE;
        out_id_i    = 2'd1;
        out_ready_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid_o}, 32'h0);
        check("midrst_id_count", {12'b0, id_count_o}, 32'h0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check("after_rst_in_ready", {31'b0, in_ready_o}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd0, 32'h0, 2'(k), 1'b0);
            check($sformatf("after_rst_empty%0d", k), {31'b0, out_valid_o}, 32'h0);
        end
        step(1'b1, 2'd1, 32'h77, 2'd1, 1'b0);
        step(1'b0, 2'd0, 32'h0,  2'd1, 1'b0);
        check("after_rst_enq_valid", {31'b0, out_valid_o}, 32'h1);
        check("after_rst_enq_data", out_data_o, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simmem_linkedlist_bank.md
SIMMEM_LINKEDLIST_BANK -- requirements
Module: simmem_linkedlist_bank

Interface
REQ-001 SHALL have parameter NumIds, default 4, number of independent per-ID queues (>=2, power of two).
REQ-002 SHALL have parameter TotalCapacity, default 16, shared entries across all IDs (>=2, power of two).
REQ-003 SHALL have parameter DataWidth, default 32, payload width in bits.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid_i  input  1  enqueue request.
REQ-007 SHALL have port in_ready_o  output  1  bank can accept an entry.
REQ-008 SHALL have port in_id_i  input  log2(NumIds)  target queue of enqueue.
REQ-009 SHALL have port in_data_i  input  DataWidth  enqueue payload.
REQ-010 SHALL have port out_id_i  input  log2(NumIds)  queue selected for release.
REQ-011 SHALL have port out_valid_o  output  1  selected queue non-empty.
REQ-012 SHALL have port out_ready_i  input  1  consumer takes head of selected queue.
REQ-013 SHALL have port out_data_o  output  DataWidth  head payload of selected queue.
REQ-014 SHALL have port id_count_o  output  NumIds*(log2(TotalCapacity)+1)  per-ID occupancy, ID 0 in LSBs.

Function
REQ-015 SHALL store payloads in a struct RAM and link pointers in a next-element RAM, both TotalCapacity deep, flop-based.
REQ-016 SHALL track free entries in a TotalCapacity-bit mask; enqueue allocates the lowest-index free entry.
REQ-017 SHALL keep per ID: head pointer, tail pointer, occupancy count (0..TotalCapacity).
REQ-018 in_ready_o SHALL be 1 iff at least one entry is free in the current-cycle state; never depends on same-cycle release.
REQ-019 Enqueue SHALL fire on in_valid_i && in_ready_o: write payload to allocated entry, clear its free bit, count+1.
REQ-020 Enqueue into empty queue SHALL set head and tail to the allocated entry; otherwise next-element[old tail] <= allocated entry, tail <= allocated entry.
REQ-021 out_valid_o SHALL equal (count[out_id_i] != 0), combinationally from registered state.
REQ-022 out_data_o SHALL equal struct RAM[head[out_id_i]], combinational; undefined value permitted only when out_valid_o=0.
REQ-023 Release SHALL fire on out_valid_o && out_ready_i: set free bit of head entry, head <= next-element[head], count-1.
REQ-024 Entry enqueued in cycle N SHALL be visible at out_data_o (if it is head) in cycle N+1; no same-cycle bypass.
REQ-025 Simultaneous enqueue and release on different IDs SHALL both complete in the same cycle.
REQ-026 Simultaneous enqueue and release on the same ID with count=1 SHALL leave count=1, head=tail=newly allocated entry.
REQ-027 Simultaneous enqueue and release on same ID with count>1 SHALL apply both; count unchanged.
REQ-028 Entry freed in cycle N SHALL be allocatable from cycle N+1 onward, not in cycle N.
REQ-029 Per-ID order SHALL be strict FIFO; no ordering between different IDs.
REQ-030 Pointer and index arithmetic SHALL be log2(TotalCapacity) bits wide, no wrap beyond capacity; counts use one extra bit.

Reset
REQ-031 On rst_i=1 (asynchronous) all free bits SHALL be 1, all counts, heads, tails 0; RAM contents need not reset.
REQ-032 During and after reset: in_ready_o=1 (after deassertion), out_valid_o=0, id_count_o=0.
REQ-033 Reset mid-operation SHALL discard all queued entries with no pending release completing.

Configuration
REQ-034 Macro SIMMEM_BANK_OCCUPANCY_EN, when defined, SHALL drive id_count_o with live per-ID counts.
REQ-035 Without SIMMEM_BANK_OCCUPANCY_EN, id_count_o SHALL be tied to 0; internal behaviour otherwise identical.

Verification
REQ-036 Reset, then enqueue ID1 data 0xA, 0xB, 0xC in consecutive cycles; release ID1 x3 -> out_data_o 0xA, 0xB, 0xC in order, then out_valid_o=0.
REQ-037 Fill all 16 entries alternating ID0/ID3 -> in_ready_o=0 after 16th accept; release one ID0 with in_valid_i=1 -> no accept that cycle, accept next cycle at freed index.
REQ-038 ID2 holds 0x5 only; same cycle enqueue ID2 0x6 and release ID2 -> next cycle out_data_o=0x6, count[2]=1.
REQ-039 Enqueue ID0 0x1 and release ID3 (holding 0x9) same cycle -> both complete; counts ID0 +1, ID3 -1.
REQ-040 Assert rst_i mid-cycle with 5 entries queued -> immediately out_valid_o=0, id_count_o=0; after release in_ready_o=1.
REQ-041 Build with and without SIMMEM_BANK_OCCUPANCY_EN, 3 entries on ID1 -> id_count_o field 1 equals 3 resp. 0.
